// File: rtl/wb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state
// encoding, default bus widths and the round-robin pick helper.
package wb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  // Round-robin choice between the two requesters; 'last' is the master
  // that most recently owned the bus, so the other one wins a tie.
  function automatic arb_state_e rr_pick(input logic cyc0, input logic cyc1,
                                         input logic last);
    arb_state_e pick;
    if (cyc0 && cyc1) pick = last ? GNT0 : GNT1;
    else if (cyc0)    pick = GNT0;
    else if (cyc1)    pick = GNT1;
    else              pick = IDLE;
    return pick;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating stall counter for the arbiter watchdog. 'expired' is high in
// the cycle that is the TIMEOUT-th consecutive enabled (stalled) cycle.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // cnt holds the number of stalled cycles already completed, so the
  // current stalled cycle is number cnt+1.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  // Count consecutive stalled cycles, clearing on request, holding at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop updating from the
    // pre-edge values, so block ordering cannot change the result.
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, single-slave Wishbone arbiter. Registered round-robin grant
// held for a whole cyc transaction, combinational ack/data return, and a
// watchdog that ends a stalled strobe with a one-cycle err pulse followed
// by a one-cycle idle gap on the slave bus.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  // master 0 (CPU data port)
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1 (DMA / debug loader)
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // slave
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  // debug
  output logic [1:0]    gnt_o
);

  arb_state_e state, state_next;
  logic       last, last_next;
  logic       own_cyc, own_stb;
  logic       stall_en, stall_clr, expired;

  // cyc/stb of whichever master currently owns the bus (0 when nobody does).
  assign own_cyc = (state == GNT0) ? m0_cyc_i :
                   (state == GNT1) ? m1_cyc_i : 1'b0;
  assign own_stb = (state == GNT0) ? m0_stb_i :
                   (state == GNT1) ? m1_stb_i : 1'b0;

  // A cycle counts as stalled when the owner strobes and the slave does not
  // ack; an ack in the expiry cycle therefore suppresses the err.
  assign stall_en  = own_cyc && own_stb && !s_ack_i;
  assign stall_clr = !stall_en || (state_next != state);

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (stall_clr),
    .en      (stall_en),
    .expired (expired)
  );

  // Grant state and round-robin pointer; reset favours master 0 on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next grant: arbitrate when free, release on cyc low, abort on timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next = state;
    last_next  = last;
    unique case (state)
      // ABORT is itself the idle gap, so it arbitrates exactly like IDLE
      // and a pending master is granted straight after the gap.
      IDLE, ABORT: state_next = rr_pick(m0_cyc_i, m1_cyc_i, last);
      GNT0: begin
        if (!m0_cyc_i) begin
          last_next  = 1'b0;
          state_next = m1_cyc_i ? GNT1 : IDLE;
        end else if (expired) begin
          last_next  = 1'b0;
          state_next = ABORT;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_next  = 1'b1;
          state_next = m0_cyc_i ? GNT0 : IDLE;
        end else if (expired) begin
          last_next  = 1'b1;
          state_next = ABORT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux from the owner and termination routing back to it.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = expired;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = expired;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the owner sees an ack qualifying it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign gnt_o = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus a random
// phase, every cycle compared against a transaction-level ownership model.
module tb_wb_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i, m0_dat_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i, m1_dat_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the bus (-1 none), who owned it last, and how
  // many consecutive stalled strobe cycles the owner has accumulated.
  int owner  = -1;
  int last_g = 1;
  int stall  = 0;

  // DUT observations captured at the last sampling point of step().
  logic [1:0]    c_gnt;
  logic          c_scyc, c_m0_ack, c_m0_err, c_m1_ack, c_m1_err;
  logic [AW-1:0] c_sadr;
  logic [DW-1:0] c_m0_dat;

  int rem[2];
  int acks[2];
  bit drop[2];
  bit r_cyc[2];
  int seq[$];
  int errk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic c, input logic s,
                       input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (i == 0) begin
      m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_adr_i = a; m0_dat_i = d;
    end else begin
      m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_adr_i = a; m1_dat_i = d;
    end
  endtask

  // One clock cycle: compare all outputs against the model mid-cycle, then
  // advance the model with the inputs present at the rising edge.
  task automatic step();
    logic          oc, os, ow, stalled, tmo, ocyc_now, other_cyc;
    logic [AW-1:0] oa;
    logic [DW-1:0] od;
    logic [1:0]    eg;
    @(negedge clk);
    oc = 1'b0; os = 1'b0; ow = 1'b0; oa = '0; od = '0; eg = 2'b00;
    if (owner == 0) begin
      oc = m0_cyc_i; os = m0_stb_i; ow = m0_we_i; oa = m0_adr_i; od = m0_dat_i;
      eg = 2'b01;
    end else if (owner == 1) begin
      oc = m1_cyc_i; os = m1_stb_i; ow = m1_we_i; oa = m1_adr_i; od = m1_dat_i;
      eg = 2'b10;
    end
    stalled = oc && os && !s_ack_i;
    tmo     = stalled && (stall + 1 == TO);
    check("gnt",    gnt_o,    eg);
    check("s_cyc",  s_cyc_o,  oc);
    check("s_stb",  s_stb_o,  os);
    check("s_we",   s_we_o,   ow);
    check("s_adr",  s_adr_o,  oa);
    check("s_dat",  s_dat_o,  od);
    check("m0_ack", m0_ack_o, (owner == 0) && s_ack_i);
    check("m1_ack", m1_ack_o, (owner == 1) && s_ack_i);
    check("m0_err", m0_err_o, (owner == 0) && tmo);
    check("m1_err", m1_err_o, (owner == 1) && tmo);
    check("m0_dat", m0_dat_o, s_dat_i);
    check("m1_dat", m1_dat_o, s_dat_i);
    c_gnt = gnt_o; c_scyc = s_cyc_o; c_sadr = s_adr_o; c_m0_dat = m0_dat_o;
    c_m0_ack = m0_ack_o; c_m0_err = m0_err_o;
    c_m1_ack = m1_ack_o; c_m1_err = m1_err_o;
    @(posedge clk);
    if (owner >= 0) begin
      ocyc_now  = (owner == 0) ? m0_cyc_i : m1_cyc_i;
      other_cyc = (owner == 0) ? m1_cyc_i : m0_cyc_i;
      if (!ocyc_now) begin
        last_g = owner;
        owner  = other_cyc ? 1 - owner : -1;
        stall  = 0;
      end else if (tmo) begin
        last_g = owner;
        owner  = -1;
        stall  = 0;
      end else begin
        stall = stalled ? stall + 1 : 0;
      end
    end else begin
      if (m0_cyc_i && m1_cyc_i) owner = 1 - last_g;
      else if (m0_cyc_i)        owner = 0;
      else if (m1_cyc_i)        owner = 1;
      else                      owner = -1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    s_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_inputs();
    s_dat_i = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    step();
    check("reset_gnt", c_gnt, 2'b00);

    // Tie after reset: m0 first, then m1 with no idle bubble
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h200, 32'h55);
    step();
    check("tie_pending", c_gnt, 2'b00);
    step();
    check("tie_gnt0", c_gnt, 2'b01);
    s_ack_i = 1'b1; s_dat_i = 32'h1234;
    step();
    check("tie_m0_ack", c_m0_ack, 1'b1);
    check("tie_m1_noack", c_m1_ack, 1'b0);
    s_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    check("handover_gnt1", c_gnt, 2'b10);
    s_ack_i = 1'b1;
    step();
    check("tie_m1_ack", c_m1_ack, 1'b1);
    idle_inputs();
    step();
    step();

    // Round-robin: four single-beat cycles per master
    rem  = '{4, 4};
    acks = '{0, 0};
    drop = '{1'b0, 1'b0};
    for (int n = 0; n < 80 && (rem[0] > 0 || rem[1] > 0); n++) begin
      for (int i = 0; i < 2; i++) begin
        logic c;
        c = (rem[i] > 0) && !drop[i];
        set_m(i, c, c, i[0], 32'h1000 + AW'(n), DW'($urandom));
      end
      s_ack_i = (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
      s_dat_i = DW'($urandom);
      step();
      drop = '{1'b0, 1'b0};
      if (c_m0_ack) begin rem[0]--; acks[0]++; drop[0] = 1'b1; seq.push_back(0); end
      if (c_m1_ack) begin rem[1]--; acks[1]++; drop[1] = 1'b1; seq.push_back(1); end
    end
    check("rr_done", rem[0] + rem[1], 0);
    check("rr_acks0", acks[0], 4);
    check("rr_acks1", acks[1], 4);
    foreach (seq[k]) check("rr_order", seq[k], k % 2);
    idle_inputs();
    step();
    step();

    // Single master read of 0x10, slave acks two cycles after the request
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    step();
    check("sm_cyc_n", c_scyc, 1'b0);
    step();
    check("sm_cyc_n1", c_scyc, 1'b1);
    check("sm_adr", c_sadr, 32'h10);
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
    step();
    check("sm_m0_ack", c_m0_ack, 1'b1);
    check("sm_m0_dat", c_m0_dat, 32'hDEADBEEF);
    check("sm_m1_noack", c_m1_ack, 1'b0);
    idle_inputs();
    step();
    step();

    // Timeout: m1 write never acked, m0 becomes pending meanwhile
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h300, 32'hA5A5);
    step();
    errk = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 2) set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
      step();
      if (c_m1_err) begin errk = k; break; end
    end
    check("to_err_cycle", errk, TO);
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    step();
    check("to_gap_cyc", c_scyc, 1'b0);
    check("to_gap_gnt", c_gnt, 2'b00);
    check("to_no_2nd_err", c_m1_err, 1'b0);
    step();
    check("to_m0_gnt", c_gnt, 2'b01);
    s_ack_i = 1'b1;
    step();
    idle_inputs();
    step();
    step();

    // Ack exactly on the expiry cycle wins over the watchdog
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h500, 32'h77);
    step();
    for (int k = 1; k <= TO; k++) begin
      s_ack_i = (k == TO);
      step();
    end
    check("exp_ack", c_m0_ack, 1'b1);
    check("exp_no_err", c_m0_err, 1'b0);
    s_ack_i = 1'b0;
    step();
    check("exp_still_gnt", c_gnt, 2'b01);
    idle_inputs();
    step();
    step();

    // Asynchronous reset while m0 owns the bus
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0);
    step();
    step();
    s_ack_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_ack", m0_ack_o, 1'b0);
    check("rst_err", m0_err_o, 1'b0);
    owner = -1; last_g = 1; stall = 0;
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h700, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0);
    step();
    step();
    check("rst_tie_gnt0", c_gnt, 2'b01);
    idle_inputs();
    step();
    step();
    step();

    // Random phase: sticky requests, ack rate varying from none to high
    r_cyc = '{1'b0, 1'b0};
    for (int n = 0; n < 600; n++) begin
      int pct;
      pct = ((n / 60) % 3) * 40;
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) == 0) r_cyc[i] = ~r_cyc[i];
        set_m(i, r_cyc[i], r_cyc[i] && ($urandom_range(0, 9) != 0),
              1'($urandom), AW'($urandom), DW'($urandom));
      end
      s_ack_i = ($urandom_range(0, 99) < pct);
      s_dat_i = DW'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
